mem_access_ctrl: RTL and testbench

//  Initiator side of the byte-wide data-memory port. Accepts one load/store per

---
 rtl/mem_access_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - byte-serial big-endian load/store initiator; optional MISALIGN_TRAP_EN misalignment trap
module mem_access_ctrl #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_t;

   state_t              state, state_nx;
   logic [1:0]          idx, idx_nx;        // byte currently on the bus
   logic [1:0]          last, last_nx;      // index of final byte (0, 1 or 3)
   logic                is_wr, is_wr_nx;
   logic                is_uns, is_uns_nx;
   logic                rd_pend;            // mem_rdata carries a byte this cycle
   logic [31:0]         shreg, shreg_nx;    // remaining store bytes, MSB first
   logic [31:0]         acc, acc_nx;        // load bytes in arrival order
   logic [ADDR_W-1:0]   mem_addr_nx;
   logic                mem_re_nx, mem_we_nx;
   logic [7:0]          mem_wdata_nx;
   logic                resp_valid_nx, resp_err_nx;
   logic [31:0]         resp_rdata_nx;

   logic [1:0]          req_last;
   logic [ADDR_W-1:0]   req_base;
   logic [31:0]         req_lj;
   logic                unused_addr_bits;

   assign req_ready        = (state == S_IDLE);
   assign unused_addr_bits = ^req_addr[31:ADDR_W];

   // Extend the right-justified N-byte load value to 32 bits.
   function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] l, input logic u);
      logic [31:0] r;
      case (l)
         2'd0:    r = {{24{v[7] & ~u}}, v[7:0]};
         2'd1:    r = {{16{v[15] & ~u}}, v[15:0]};
         default: r = v;
      endcase
      return r;
   endfunction

   // Decode request size, aligned base address and left-justified store operand.
   always_comb begin
      req_last = 2'd3;
      req_base = req_addr[ADDR_W-1:0];
      req_lj   = req_wdata;
      case (req_size)
         2'd0: begin
            req_last = 2'd0;
            req_lj   = {req_wdata[7:0], 24'h0};
         end
         2'd1: begin
            req_last    = 2'd1;
            req_base[0] = 1'b0;
            req_lj      = {req_wdata[15:0], 16'h0};
         end
         default: begin
            req_last      = 2'd3;
            req_base[1:0] = 2'b00;
         end
      endcase
   end

   // Next-state and next-output logic; all outputs are registered.
   always_comb begin
      state_nx      = state;
      idx_nx        = idx;
      last_nx       = last;
      is_wr_nx      = is_wr;
      is_uns_nx     = is_uns;
      shreg_nx      = shreg;
      acc_nx        = acc;
      mem_addr_nx   = mem_addr;
      mem_re_nx     = 1'b0;
      mem_we_nx     = 1'b0;
      mem_wdata_nx  = 8'h00;
      resp_valid_nx = 1'b0;
      resp_rdata_nx = 32'h0;
      resp_err_nx   = 1'b0;

      if (rd_pend) acc_nx = {acc[23:0], mem_rdata};

      case (state)
         S_IDLE: begin
            if (req_valid) begin
`ifdef MISALIGN_TRAP_EN
               if ((req_last == 2'd1 && req_addr[0]) ||
                   (req_last == 2'd3 && req_addr[1:0] != 2'b00)) begin
                  state_nx      = S_RESP;
                  resp_valid_nx = 1'b1;
                  resp_err_nx   = 1'b1;
               end else begin
`else
               begin
`endif
                  state_nx     = S_ISSUE;
                  idx_nx       = 2'd0;
                  last_nx      = req_last;
                  is_wr_nx     = req_write;
                  is_uns_nx    = req_unsigned;
                  acc_nx       = 32'h0;
                  mem_addr_nx  = req_base;
                  mem_we_nx    = req_write;
                  mem_re_nx    = ~req_write;
                  mem_wdata_nx = req_write ? req_lj[31:24] : 8'h00;
                  shreg_nx     = req_lj << 8;
               end
            end
         end
         S_ISSUE: begin
            if (idx == last) begin
               state_nx      = is_wr ? S_RESP : S_DRAIN;
               resp_valid_nx = is_wr;
            end else begin
               idx_nx       = idx + 2'd1;
               mem_addr_nx  = mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
               mem_we_nx    = is_wr;
               mem_re_nx    = ~is_wr;
               mem_wdata_nx = is_wr ? shreg[31:24] : 8'h00;
               shreg_nx     = shreg << 8;
            end
         end
         S_DRAIN: begin
            state_nx      = S_RESP;
            resp_valid_nx = 1'b1;
            resp_rdata_nx = extend(acc_nx, last, is_uns);
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any transfer in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         idx        <= 2'd0;
         last       <= 2'd0;
         is_wr      <= 1'b0;
         is_uns     <= 1'b0;
         rd_pend    <= 1'b0;
         shreg      <= 32'h0;
         acc        <= 32'h0;
         mem_addr   <= '0;
         mem_re     <= 1'b0;
         mem_we     <= 1'b0;
         mem_wdata  <= 8'h00;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         last       <= last_nx;
         is_wr      <= is_wr_nx;
         is_uns     <= is_uns_nx;
         rd_pend    <= mem_re;
         shreg      <= shreg_nx;
         acc        <= acc_nx;
         mem_addr   <= mem_addr_nx;
         mem_re     <= mem_re_nx;
         mem_we     <= mem_we_nx;
         mem_wdata  <= mem_wdata_nx;
         resp_valid <= resp_valid_nx;
         resp_rdata <= resp_rdata_nx;
         resp_err   <= resp_err_nx;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl with byte memory model and response scoreboard
module tb_mem_access_ctrl;

   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic [1:0]        req_size = 2'd0;
   logic              req_unsigned = 1'b0;
   logic [31:0]       req_addr = 32'h0;
   logic [31:0]       req_wdata = 32'h0;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;

   typedef struct {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [7:0] mem [256];

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_addr     (mem_addr),
      .mem_re       (mem_re),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   // Byte-wide synchronous memory: write at the strobe edge, read data next cycle.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic xfer(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_lat, input int exp_n, input logic [7:0] exp_a0);
      int         lat;
      int         nstb;
      int         bad;
      int         extra;
      exp_t       e;
      logic [7:0] ea;
      lat = 0; nstb = 0; bad = 0; extra = 0;
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      sb_q.push_back('{rd: exp_rd, err: exp_err});
      check({tag, " ready_at_request"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
         @(negedge clk);
         ea = exp_a0 + 8'(cyc - 1);
         if (mem_re || mem_we) begin
            nstb++;
            if (cyc > exp_n || mem_addr != ea || mem_we != wr || mem_re == wr) bad++;
         end else if (cyc <= exp_n) begin
            bad++;
         end
         if (req_ready) extra++;
         if (resp_valid) begin
            lat = cyc;
            check({tag, " sb_pending"}, 32'(sb_q.size()), 32'd1);
            if (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               check({tag, " rdata"}, resp_rdata, e.rd);
               check({tag, " err"}, 32'(resp_err), 32'(e.err));
            end
         end
      end
      req_valid = 1'b0;
      if (lat == 0 && sb_q.size() > 0) void'(sb_q.pop_front());
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " strobes"}, 32'(nstb), 32'(exp_n));
      check({tag, " strobe_seq_errs"}, 32'(bad), 32'd0);
      check({tag, " extra_accepts"}, 32'(extra), 32'd0);
      @(negedge clk);
      check({tag, " ready_after"}, 32'(req_ready), 32'd1);
      check({tag, " resp_single_pulse"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;

      // Reset state
      #1 rst = 1'b0;
      #1;
      check("rst req_ready", 32'(req_ready), 32'd1);
      check("rst resp_valid", 32'(resp_valid), 32'd0);
      check("rst resp_rdata", resp_rdata, 32'h0);
      check("rst resp_err", 32'(resp_err), 32'd0);
      check("rst strobes", {30'h0, mem_re, mem_we}, 32'h0);
      check("rst mem_addr", 32'(mem_addr), 32'h0);
      check("rst mem_wdata", 32'(mem_wdata), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Reset mid-ISSUE of a word store
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      check("midrst we_before", 32'(mem_we), 32'd1);
      req_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("midrst strobes", {30'h0, mem_re, mem_we}, 32'h0);
      check("midrst req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (resp_valid) pulses++;
      end
      check("midrst no_resp", 32'(pulses), 32'd0);

      // sw / lw round trip
      xfer("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 5, 4, 8'h10);
      check("sw10 mem10", 32'(mem[8'h10]), 32'hDE);
      check("sw10 mem11", 32'(mem[8'h11]), 32'hAD);
      check("sw10 mem12", 32'(mem[8'h12]), 32'hBE);
      check("sw10 mem13", 32'(mem[8'h13]), 32'hEF);
      xfer("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 6, 4, 8'h10);

      // Byte and half accesses with sign/zero extension
      xfer("sb20", 1'b1, 2'd0, 1'b0, 32'h20, 32'h12345680, 32'h0, 1'b0, 2, 1, 8'h20);
      check("sb20 mem20", 32'(mem[8'h20]), 32'h80);
      xfer("lb20", 1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1, 8'h20);
      xfer("lbu20", 1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 32'h00000080, 1'b0, 3, 1, 8'h20);
      xfer("sh22", 1'b1, 2'd1, 1'b0, 32'h22, 32'hABCD8001, 32'h0, 1'b0, 3, 2, 8'h22);
      check("sh22 mem22", 32'(mem[8'h22]), 32'h80);
      check("sh22 mem23", 32'(mem[8'h23]), 32'h01);
      xfer("lh22", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'hFFFF8001, 1'b0, 4, 2, 8'h22);
      xfer("lhu22", 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 32'h00008001, 1'b0, 4, 2, 8'h22);

      // Misaligned word load
`ifdef MISALIGN_TRAP_EN
      xfer("lw13", 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 8'h00);
`else
      xfer("lw13", 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, 6, 4, 8'h10);
`endif

      // Top of the address space, size 3 treated as word, upper address bits ignored
      xfer("swFC", 1'b1, 2'd3, 1'b0, 32'hFFFF_FFFC, 32'h11223344, 32'h0, 1'b0, 5, 4, 8'hFC);
      check("swFC memFF", 32'(mem[8'hFF]), 32'h44);
      xfer("lwFC", 1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, 32'h11223344, 1'b0, 6, 4, 8'hFC);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
